// File: rtl/crossbar2_sched.sv
// Two-input, two-output flit scheduler feeding a 2x2 crossbar.
// One holding register per input; each output is arbitrated round-robin and held until drained.
module crossbar2_sched #(
  parameter int Width  = 8,
  parameter int Select = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN0_VALID,
  output logic              IN0_READY,
  input  logic [Width-1:0]  IN0_DATA,
  input  logic              IN0_DEST,
  input  logic              IN1_VALID,
  output logic              IN1_READY,
  input  logic [Width-1:0]  IN1_DATA,
  input  logic              IN1_DEST,
  output logic [Width-1:0]  X0,
  output logic [Width-1:0]  X1,
  output logic [Select-1:0] S0,
  output logic [Select-1:0] S1,
  output logic              OUT0_VALID,
  input  logic              OUT0_READY,
  output logic              OUT1_VALID,
  input  logic              OUT1_READY
);

  logic              rdy_en;
  logic [1:0]        full, launched, dest, pri, out_valid;
  logic [Width-1:0]  hold0, hold1;
  logic [Select-1:0] sel0, sel1;

  logic [1:0] in_valid, out_ready, accept, cand0, cand1, grant0, grant1, drain, launch;

  // Select codes are one-hot per source, so a grant mask doubles as the route code.
  always_comb begin
    in_valid  = {IN1_VALID, IN0_VALID};
    out_ready = {OUT1_READY, OUT0_READY};
    accept    = in_valid & ~full & {2{rdy_en}};
    cand0     = full & ~launched & ~dest;
    cand1     = full & ~launched & dest;
    grant0    = (cand0 == 2'b11) ? (pri[0] ? 2'b10 : 2'b01) : cand0;
    grant1    = (cand1 == 2'b11) ? (pri[1] ? 2'b10 : 2'b01) : cand1;
    launch    = (out_valid[0] ? 2'b00 : grant0) | (out_valid[1] ? 2'b00 : grant1);
    drain     = ((out_valid[0] & out_ready[0]) ? sel0[1:0] : 2'b00)
              | ((out_valid[1] & out_ready[1]) ? sel1[1:0] : 2'b00);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_en    <= 1'b0;
      full      <= '0;
      launched  <= '0;
      dest      <= '0;
      pri       <= '0;
      out_valid <= '0;
      hold0     <= '0;
      hold1     <= '0;
      sel0      <= '0;
      sel1      <= '0;
    end else begin
      rdy_en   <= 1'b1;
      full     <= (full & ~drain) | accept;
      launched <= (launched & ~drain) | launch;
      if (accept[0]) begin
        hold0   <= IN0_DATA;
        dest[0] <= IN0_DEST;
      end
      if (accept[1]) begin
        hold1   <= IN1_DATA;
        dest[1] <= IN1_DEST;
      end
      // A busy output only drains; relaunch waits for the following edge.
      if (out_valid[0]) begin
        if (out_ready[0]) begin
          out_valid[0] <= 1'b0;
          sel0         <= '0;
        end
      end else if (grant0 != 2'b00) begin
        out_valid[0] <= 1'b1;
        sel0         <= grant0;
        if (cand0 == 2'b11) pri[0] <= ~pri[0];
      end
      if (out_valid[1]) begin
        if (out_ready[1]) begin
          out_valid[1] <= 1'b0;
          sel1         <= '0;
        end
      end else if (grant1 != 2'b00) begin
        out_valid[1] <= 1'b1;
        sel1         <= grant1;
        if (cand1 == 2'b11) pri[1] <= ~pri[1];
      end
    end
  end

  assign IN0_READY  = ~full[0] & rdy_en;
  assign IN1_READY  = ~full[1] & rdy_en;
  assign X0         = hold0;
  assign X1         = hold1;
  assign S0         = sel0;
  assign S1         = sel1;
  assign OUT0_VALID = out_valid[0];
  assign OUT1_VALID = out_valid[1];

endmodule

// File: tb/tb_crossbar2_sched.sv
// Directed testbench for crossbar2_sched with hand-computed expectations.
module tb_crossbar2_sched;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       IN0_VALID, IN0_READY, IN0_DEST;
  logic       IN1_VALID, IN1_READY, IN1_DEST;
  logic [7:0] IN0_DATA, IN1_DATA, X0, X1;
  logic [1:0] S0, S1;
  logic       OUT0_VALID, OUT0_READY, OUT1_VALID, OUT1_READY;

  int n_cmp = 0;
  int n_err = 0;

  crossbar2_sched #(.Width(8), .Select(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN0_VALID(IN0_VALID), .IN0_READY(IN0_READY), .IN0_DATA(IN0_DATA), .IN0_DEST(IN0_DEST),
    .IN1_VALID(IN1_VALID), .IN1_READY(IN1_READY), .IN1_DATA(IN1_DATA), .IN1_DEST(IN1_DEST),
    .X0(X0), .X1(X1), .S0(S0), .S1(S1),
    .OUT0_VALID(OUT0_VALID), .OUT0_READY(OUT0_READY),
    .OUT1_VALID(OUT1_VALID), .OUT1_READY(OUT1_READY)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    IN0_VALID = 0; IN0_DATA = '0; IN0_DEST = 0;
    IN1_VALID = 0; IN1_DATA = '0; IN1_DEST = 0;
  endtask

  task automatic test_reset;
    logic [23:0] outs;
    RST_N = 0;
    for (int i = 0; i < 4; i++) begin
      IN0_VALID = 1'($urandom); IN0_DATA = 8'($urandom); IN0_DEST = 1'($urandom);
      IN1_VALID = 1'($urandom); IN1_DATA = 8'($urandom); IN1_DEST = 1'($urandom);
      OUT0_READY = 1'($urandom); OUT1_READY = 1'($urandom);
      tick();
      outs = {X0, X1, S0, S1, OUT0_VALID, OUT1_VALID, IN0_READY, IN1_READY};
      n_cmp++;
      if (outs !== 24'h0) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: got %h expected 000000", i, outs);
      end
    end
    idle_inputs();
    OUT0_READY = 0; OUT1_READY = 0;
    #2 RST_N = 1;
    #1;
    n_cmp++;
    if ({IN0_READY, IN1_READY} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_ready_delay: got %b expected 00", {IN0_READY, IN1_READY});
    end
    tick();
    n_cmp++;
    if ({IN0_READY, IN1_READY} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_ready_rise: got %b expected 11", {IN0_READY, IN1_READY});
    end
  endtask

  task automatic test_single_route;
    OUT1_READY = 1;
    IN0_VALID = 1; IN0_DATA = 8'h01; IN0_DEST = 1;
    tick();
    idle_inputs();
    n_cmp++;
    if ({IN0_READY, OUT1_VALID, X0} !== {1'b0, 1'b0, 8'h01}) begin
      n_err++;
      $display("FAIL single_accept: got rdy=%b v=%b x0=%h expected rdy=0 v=0 x0=01", IN0_READY, OUT1_VALID, X0);
    end
    tick();
    n_cmp++;
    if ({OUT1_VALID, S1, X0} !== {1'b1, 2'b01, 8'h01}) begin
      n_err++;
      $display("FAIL single_launch: got v=%b s1=%b x0=%h expected v=1 s1=01 x0=01", OUT1_VALID, S1, X0);
    end
    tick();
    n_cmp++;
    if ({OUT1_VALID, S1, IN0_READY, X0} !== {1'b0, 2'b00, 1'b1, 8'h01}) begin
      n_err++;
      $display("FAIL single_drain: got v=%b s1=%b rdy=%b x0=%h expected v=0 s1=00 rdy=1 x0=01", OUT1_VALID, S1, IN0_READY, X0);
    end
  endtask

  task automatic test_parallel;
    OUT0_READY = 1; OUT1_READY = 1;
    IN0_VALID = 1; IN0_DATA = 8'h01; IN0_DEST = 1;
    IN1_VALID = 1; IN1_DATA = 8'h02; IN1_DEST = 0;
    tick();
    idle_inputs();
    tick();
    n_cmp++;
    if ({OUT0_VALID, S0, OUT1_VALID, S1} !== {1'b1, 2'b10, 1'b1, 2'b01}) begin
      n_err++;
      $display("FAIL parallel_launch: got v0=%b s0=%b v1=%b s1=%b expected v0=1 s0=10 v1=1 s1=01", OUT0_VALID, S0, OUT1_VALID, S1);
    end
    tick();
    n_cmp++;
    if ({OUT0_VALID, S0, OUT1_VALID, S1} !== 6'b0) begin
      n_err++;
      $display("FAIL parallel_drain: got v0=%b s0=%b v1=%b s1=%b expected all 0", OUT0_VALID, S0, OUT1_VALID, S1);
    end
  endtask

  task automatic test_conflict_rr;
    logic [1:0] exp_a [10];
    logic [1:0] exp_b [4];
    exp_a = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    exp_b = '{2'b10, 2'b00, 2'b01, 2'b00};
    OUT0_READY = 1; OUT1_READY = 0;
    // Both inputs keep offering flits to Y0; grants must alternate with an idle gap.
    IN0_VALID = 1; IN0_DATA = 8'h01; IN0_DEST = 0;
    IN1_VALID = 1; IN1_DATA = 8'h02; IN1_DEST = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 6) idle_inputs();
      n_cmp++;
      if ({OUT0_VALID, S0} !== {exp_a[i] != 2'b00, exp_a[i]}) begin
        n_err++;
        $display("FAIL conflict_seq[%0d]: got v=%b s0=%b expected v=%b s0=%b", i, OUT0_VALID, S0, exp_a[i] != 2'b00, exp_a[i]);
      end
    end
    n_cmp++;
    if ({X0, X1} !== 16'h0102) begin
      n_err++;
      $display("FAIL conflict_data: got %h expected 0102", {X0, X1});
    end
    // Output 0 priority now points at input 1.
    IN0_VALID = 1; IN0_DATA = 8'h11; IN0_DEST = 0;
    IN1_VALID = 1; IN1_DATA = 8'h22; IN1_DEST = 0;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({OUT0_VALID, S0} !== {exp_b[i] != 2'b00, exp_b[i]}) begin
        n_err++;
        $display("FAIL rr_toggle[%0d]: got v=%b s0=%b expected v=%b s0=%b", i, OUT0_VALID, S0, exp_b[i] != 2'b00, exp_b[i]);
      end
    end
    n_cmp++;
    if ({X0, X1} !== 16'h1122) begin
      n_err++;
      $display("FAIL rr_data: got %h expected 1122", {X0, X1});
    end
  endtask

  task automatic test_backpressure;
    OUT1_READY = 0;
    IN1_VALID = 1; IN1_DATA = 8'h5A; IN1_DEST = 1;
    tick();
    IN1_DATA = 8'hFF;
    tick();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({OUT1_VALID, S1, X1, IN1_READY} !== {1'b1, 2'b10, 8'h5A, 1'b0}) begin
        n_err++;
        $display("FAIL backpressure[%0d]: got v=%b s1=%b x1=%h rdy=%b expected v=1 s1=10 x1=5a rdy=0", i, OUT1_VALID, S1, X1, IN1_READY);
      end
      tick();
    end
    idle_inputs();
    OUT1_READY = 1;
    tick();
    n_cmp++;
    if ({OUT1_VALID, S1, X1, IN1_READY} !== {1'b0, 2'b00, 8'h5A, 1'b1}) begin
      n_err++;
      $display("FAIL backpressure_release: got v=%b s1=%b x1=%h rdy=%b expected v=0 s1=00 x1=5a rdy=1", OUT1_VALID, S1, X1, IN1_READY);
    end
  endtask

  task automatic test_mid_reset;
    logic [23:0] outs;
    OUT0_READY = 0;
    IN0_VALID = 1; IN0_DATA = 8'h66; IN0_DEST = 0;
    IN1_VALID = 1; IN1_DATA = 8'h77; IN1_DEST = 0;
    tick();
    idle_inputs();
    tick();
    n_cmp++;
    if ({OUT0_VALID, S0} !== 3'b101) begin
      n_err++;
      $display("FAIL midreset_setup: got v=%b s0=%b expected v=1 s0=01", OUT0_VALID, S0);
    end
    #2 RST_N = 0;
    #1;
    outs = {X0, X1, S0, S1, OUT0_VALID, OUT1_VALID, IN0_READY, IN1_READY};
    n_cmp++;
    if (outs !== 24'h0) begin
      n_err++;
      $display("FAIL midreset_clear: got %h expected 000000", outs);
    end
    tick();
    #2 RST_N = 1;
    #1;
    n_cmp++;
    if ({IN0_READY, IN1_READY} !== 2'b00) begin
      n_err++;
      $display("FAIL midreset_ready_delay: got %b expected 00", {IN0_READY, IN1_READY});
    end
    tick();
    tick();
    n_cmp++;
    if ({OUT0_VALID, S0, IN0_READY, IN1_READY} !== {1'b0, 2'b00, 2'b11}) begin
      n_err++;
      $display("FAIL midreset_no_ghost: got v=%b s0=%b rdy=%b%b expected v=0 s0=00 rdy=11", OUT0_VALID, S0, IN0_READY, IN1_READY);
    end
    OUT0_READY = 1;
    IN0_VALID = 1; IN0_DATA = 8'h44; IN0_DEST = 0;
    IN1_VALID = 1; IN1_DATA = 8'h55; IN1_DEST = 0;
    tick();
    idle_inputs();
    tick();
    n_cmp++;
    if ({OUT0_VALID, S0, X0} !== {1'b1, 2'b01, 8'h44}) begin
      n_err++;
      $display("FAIL midreset_pri: got v=%b s0=%b x0=%h expected v=1 s0=01 x0=44", OUT0_VALID, S0, X0);
    end
  endtask

  initial begin
    RST_N = 0;
    idle_inputs();
    OUT0_READY = 0; OUT1_READY = 0;
    test_reset();
    test_single_route();
    test_parallel();
    test_conflict_rr();
    test_backpressure();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
